// File: rtl/complete_arbiter_pkg.sv
// complete_arbiter_pkg: CompleteInfo message types shared by the completion path.
package complete_arbiter_pkg;
    localparam int CID_W = 8;
    localparam logic KIND_WB = 1'b0;
    localparam logic KIND_BRANCH = 1'b1;
    typedef logic [CID_W-1:0] commit_id_t;
    typedef struct packed {
        logic [1:0]  pad;
        logic [31:0] data;
    } wb_t;
    typedef struct packed {
        logic        miss;
        logic        taken;
        logic [31:0] new_pc;
    } branch_t;
    typedef union packed {
        wb_t     wb;
        branch_t branch;
    } content_t;
    typedef struct packed {
        commit_id_t commit_id;
        logic       kind;
        content_t   content;
    } complete_info_t;
endpackage

// File: rtl/complete_arbiter_if.sv
// complete_if: en/msg/reject message channel carrying one CompleteInfo per transfer.
interface complete_if;
    import complete_arbiter_pkg::*;
    logic           en;
    complete_info_t msg;
    logic           reject;
    modport sender(output en, output msg, input reject);
    modport receiver(input en, input msg, output reject);
endinterface

// File: rtl/complete_arbiter_fifo.sv
// complete_fifo: single-source completion FIFO; distributed RAM, pointers wrap mod depth.
module complete_fifo
    import complete_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  complete_info_t              din,
    output complete_info_t              head,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    complete_info_t mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign head  = mem[rd_ptr];
    assign full  = count == CW'(FIFO_DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/complete_arbiter.sv
// complete_arbiter: buffers per-unit completions and round-robins them into one registered output.
// Define BRANCH_PRIORITY_EN to let branch-kind heads win over writeback heads.
module complete_arbiter
    import complete_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    complete_if.receiver src [NUM_SRC],
    complete_if.sender   complete_info,
    output logic       busy
);
    localparam int PW = $clog2(NUM_SRC);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [NUM_SRC-1:0] push, pop, full, empty, occ, cand;
    complete_info_t head [NUM_SRC];
    logic [CW-1:0] cnt [NUM_SRC];
    logic [PW-1:0] rr_ptr, gnt, idx;
    logic gnt_valid, load, out_valid;
    complete_info_t out_msg;
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src[i].reject = full[i];
        assign push[i] = src[i].en && !full[i];
        assign pop[i] = load && gnt_valid && (gnt == PW'(i));
        assign occ[i] = cnt[i] != '0;
        complete_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clock(clock),
            .reset(reset),
            .push(push[i]),
            .pop(pop[i]),
            .din(src[i].msg),
            .head(head[i]),
            .count(cnt[i]),
            .full(full[i]),
            .empty(empty[i])
        );
    end
`ifdef BRANCH_PRIORITY_EN
    logic [NUM_SRC-1:0] is_branch;
    for (genvar b = 0; b < NUM_SRC; b++) begin : g_kind
        assign is_branch[b] = head[b].kind == KIND_BRANCH;
    end
    assign cand = |(~empty & is_branch) ? (~empty & is_branch) : ~empty;
`else
    assign cand = ~empty;
`endif
    // Scan from the farthest offset down so the one nearest rr_ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt = '0;
        idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr) + k) % NUM_SRC);
            if (cand[idx]) begin
                gnt_valid = 1'b1;
                gnt = idx;
            end
        end
    end
    assign load = !out_valid || !complete_info.reject;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_msg   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= gnt_valid;
            if (gnt_valid) begin
                out_msg <= head[gnt];
                rr_ptr  <= (gnt == PW'(NUM_SRC - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end
    assign complete_info.en  = out_valid;
    assign complete_info.msg = out_msg;
    assign busy = out_valid || |occ;
endmodule
